// File: rtl/div_pkg.sv
// Shared types for the sequential signed divider.
// State encoding is visible to the top level only; no other consumers.
// Contains: div_state_t (IDLE, CALC, FIX, DONE).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// Purpose: one radix-2 restoring division iteration on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: prem_in (BW+1 partial remainder), din (next dividend bit),
//        dvs (|divisor|), prem_out (new partial remainder), qbit (quotient bit).
module div_step #(
    parameter int BW = 19
) (
    input  logic [BW:0]   prem_in,
    input  logic          din,
    input  logic [BW-1:0] dvs,
    output logic [BW:0]   prem_out,
    output logic          qbit
);

    logic [BW+1:0] shifted;
    logic [BW:0]   diff;

    // The full-width compare decides the quotient bit; the subtraction only
    // needs BW+1 bits because a kept difference is always below |divisor|.
    assign shifted  = {prem_in, din};
    assign qbit     = (shifted >= {2'b00, dvs});
    assign diff     = shifted[BW:0] - {1'b0, dvs};
    assign prem_out = qbit ? diff : shifted[BW:0];

endmodule

// File: rtl/seq_div.sv
// Purpose: sequential signed divider, truncating quotient, remainder takes the dividend's sign.
// Latency: DW+1 cycles accept-to-out_valid (1 cycle for divide-by-zero); ce=0 stretches it 1:1.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not idle.
// Ports: clk, rst_n (async, active low), ce, in_valid/in_ready/dividend/divisor,
//        out_valid/out_ready/quot/rem/dbz/ovf.
module seq_div
    import div_pkg::*;
#(
    parameter int DW = 46,
    parameter int BW = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] dividend,
    input  logic signed [BW-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] quot,
    output logic signed [BW-1:0] rem,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int CW = $clog2(DW);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_sh;     // dividend magnitude shifts out MSB-first, quotient shifts in
    logic [BW-1:0] dvs_mag;
    logic [BW:0]   prem;
    logic          q_neg;
    logic          r_neg;
    logic          ovf_pend;

    logic [DW-1:0] dvd_abs;
    logic [BW-1:0] dvs_abs;
    logic [BW:0]   step_prem;
    logic          step_q;
    logic [BW:0]   prem_negd;
    logic [DW-1:0] quot_negd;

    // Negating the most negative value wraps to the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    assign dvd_abs   = dividend[DW-1] ? -dividend : dividend;
    assign dvs_abs   = divisor[BW-1]  ? -divisor  : divisor;
    assign prem_negd = -prem;
    assign quot_negd = -dvd_sh;

    div_step #(.BW(BW)) u_step (
        .prem_in  (prem),
        .din      (dvd_sh[DW-1]),
        .dvs      (dvs_mag),
        .prem_out (step_prem),
        .qbit     (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_sh    <= '0;
            dvs_mag   <= '0;
            prem      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_pend  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvd_sh   <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        r_neg    <= dividend[DW-1];
                        q_neg    <= dividend[DW-1] ^ divisor[BW-1];
                        prem     <= '0;
                        cnt      <= CW'(DW - 1);
                        ovf_pend <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
                        if (divisor == '0) begin
                            quot  <= '1;
                            rem   <= dividend[BW-1:0];
                            dbz   <= 1'b1;
                            ovf   <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem   <= step_prem;
                    dvd_sh <= {dvd_sh[DW-2:0], step_q};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // A positive quotient of magnitude 2^(DW-1) wraps to the
                    // most negative value, which is the overflow result.
                    quot      <= q_neg ? quot_negd : dvd_sh;
                    rem       <= r_neg ? prem_negd[BW-1:0] : prem[BW-1:0];
                    dbz       <= 1'b0;
                    ovf       <= ovf_pend;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // Divide-by-zero enters DONE with out_valid still low, so it
                    // is raised here one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    localparam int DW = 46;
    localparam int BW = 19;

    logic                 clk;
    logic                 rst_n;
    logic                 ce;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] dividend;
    logic signed [BW-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] quot;
    logic signed [BW-1:0] rem;
    logic                 dbz;
    logic                 ovf;

    int n_vec;
    int n_err;

    seq_div #(.DW(DW), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one operation and check its result.
    // gap: drop ce for 5 edges after the 10th post-accept edge.
    // hold: cycles to keep out_ready low once out_valid is seen.
    task automatic run_div(input string tag, input longint a, input longint b,
                           input longint eq, input longint er,
                           input bit edbz, input bit eovf, input int elat,
                           input bit gap, input int hold);
        int  n;
        int  w;
        bit  seen;
        longint q0;
        longint r0;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".in_ready"}, longint'(in_ready), 1);
        dividend = a[DW-1:0];
        divisor  = b[BW-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands after accept; they must not affect the result.
        dividend = {$urandom, $urandom};
        divisor  = BW'($urandom);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (gap && n == 10) ce = 1'b0;
            if (gap && n == 15) ce = 1'b1;
            if (out_valid) seen = 1'b1;
        end
        chk({tag, ".latency"}, longint'(n), longint'(elat));
        if (hold > 0) begin
            q0 = longint'(quot);
            r0 = longint'(rem);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, ".hold_vld"}, longint'(out_valid), 1);
            end
            chk({tag, ".hold_quot"}, longint'(quot), q0);
            chk({tag, ".hold_rem"}, longint'(rem), r0);
            chk({tag, ".hold_in_ready"}, longint'(in_ready), 0);
        end
        chk({tag, ".quot"}, longint'(quot), eq);
        chk({tag, ".rem"}, longint'(rem), er);
        chk({tag, ".dbz"}, longint'(dbz), longint'(edbz));
        chk({tag, ".ovf"}, longint'(ovf), longint'(eovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".vld_clear"}, longint'(out_valid), 0);
        @(negedge clk);
        chk({tag, ".ready_back"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint min45;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        min45     = -(64'sd1 <<< 45);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.in_ready", longint'(in_ready), 0);
        chk("rst.quot", longint'(quot), 0);
        chk("rst.rem", longint'(rem), 0);
        chk("rst.dbz", longint'(dbz), 0);
        chk("rst.ovf", longint'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.ready_after", longint'(in_ready), 1);

        run_div("p100_7",   100,  7,  14,  2, 1'b0, 1'b0, 47, 1'b0, 0);
        run_div("m100_7",  -100,  7, -14, -2, 1'b0, 1'b0, 47, 1'b0, 0);
        run_div("p100_m7",  100, -7, -14,  2, 1'b0, 1'b0, 47, 1'b0, 0);
        run_div("m100_m7", -100, -7,  14, -2, 1'b0, 1'b0, 47, 1'b0, 0);
        run_div("dbz", 12345, 0, -1, 12345, 1'b1, 1'b0, 1, 1'b0, 0);
        run_div("ovf", min45, -1, min45, 0, 1'b0, 1'b1, 47, 1'b0, 0);
        run_div("min_min", min45, -(64'sd1 <<< 18), 64'sd1 <<< 27, 0, 1'b0, 1'b0, 47, 1'b0, 0);
        run_div("hold", 1000, -3, -333, 1, 1'b0, 1'b0, 47, 1'b0, 10);
        run_div("ce_gap", -77, 5, -15, -2, 1'b0, 1'b0, 52, 1'b0 | 1'b1, 0);

        // Reset in the middle of a calculation; previous outputs are nonzero.
        @(negedge clk);
        dividend = 46'sd100;
        divisor  = 19'sd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", longint'(out_valid), 0);
        chk("midrst.in_ready", longint'(in_ready), 0);
        chk("midrst.quot", longint'(quot), 0);
        chk("midrst.rem", longint'(rem), 0);
        chk("midrst.dbz", longint'(dbz), 0);
        chk("midrst.ovf", longint'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("p9_3", 9, 3, 3, 0, 1'b0, 1'b0, 47, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
